// File: rtl/icon_sprite.sv
// ---------------------------------------------------------------------------
// icon_sprite
//   Produces the 2-bit bot icon pixel for the current scan position. The icon
//   is a 16x16 sprite centred on the bot location and rotated to its heading
//   in 45-degree steps. It drives the colorizer's icon input and also delays
//   video_on by two cycles, so the colorizer sees icon and video_on together.
//   Bot position, heading and stall flag are sampled into shadow registers on
//   frame_tick, so the sprite cannot tear part-way through a frame.
//
// Ports
//   clock         in   1   pixel clock (25 MHz)
//   rst           in   1   asynchronous reset, active low
//   pixel_row     in   10  current scan row
//   pixel_column  in   10  current scan column
//   video_on_in   in   1   1 = active video area
//   frame_tick    in   1   one-cycle pulse at start of vertical blanking
//   loc_x         in   8   bot X, world coordinates
//   loc_y         in   8   bot Y, world coordinates
//   orient        in   3   heading 0..7 = N,NE,E,SE,S,SW,W,NW
//   bot_stalled   in   1   1 = blink the icon
//   icon          out  2   00 transparent, 01/10/11 icon colours 1/2/3
//   video_on_out  out  1   video_on_in delayed by 2 cycles
// ---------------------------------------------------------------------------
module icon_sprite #(
    parameter int ICON_SIZE    = 16,
    parameter int LOC_SHIFT    = 2,
    parameter int BLINK_FRAMES = 32
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [9:0] pixel_row,
    input  logic [9:0] pixel_column,
    input  logic       video_on_in,
    input  logic       frame_tick,
    input  logic [7:0] loc_x,
    input  logic [7:0] loc_y,
    input  logic [2:0] orient,
    input  logic       bot_stalled,
    output logic [1:0] icon,
    output logic       video_on_out
);

    localparam int IW = $clog2(ICON_SIZE);
    localparam int BW = $clog2(BLINK_FRAMES);
    localparam int RW = 2 * ICON_SIZE;
    localparam logic [IW-1:0]      IMAX = IW'(ICON_SIZE - 1);
    localparam logic signed [10:0] HALF = 11'(ICON_SIZE / 2);

    // One entry per sprite row; pixel c occupies bits [RW-1-2c -: 2], so the
    // leftmost hex digit holds columns 0 and 1.
    localparam logic [RW-1:0] ICON_0 [ICON_SIZE] = '{
        32'h0003C000, 32'h0003C000, 32'h000FF000, 32'h000EB000,
        32'h003AAC00, 32'h003AAC00, 32'h00EAAB00, 32'h00EAAB00,
        32'h03AAAAC0, 32'h03AAAAC0, 32'h0EA55AB0, 32'h0EA55AB0,
        32'h3AA55AAC, 32'h3A9009AC, 32'h35000053, 32'h14000014
    };

    localparam logic [RW-1:0] ICON_45 [ICON_SIZE] = '{
        32'h00000003, 32'h0000003F, 32'h000003EC, 32'h00003EA8,
        32'h0003EAA0, 32'h003EAA80, 32'h03EAAA00, 32'h3EAA6800,
        32'h00A56800, 32'h00256000, 32'h00158000, 32'h00154000,
        32'h00050000, 32'h00040000, 32'h00000000, 32'h00000000
    };

    // Per-frame shadow state
    logic [7:0]    sloc_x;
    logic [7:0]    sloc_y;
    logic [2:0]    sorient;
    logic          sstall;
    logic [BW-1:0] blink_cnt;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sloc_x    <= '0;
            sloc_y    <= '0;
            sorient   <= '0;
            sstall    <= 1'b0;
            blink_cnt <= '0;
        end else if (frame_tick) begin
            sloc_x    <= loc_x;
            sloc_y    <= loc_y;
            sorient   <= orient;
            sstall    <= bot_stalled;
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // Stage 1: position relative to the sprite origin. Everything is kept
    // signed so a sprite hanging off the top/left edge clips instead of
    // wrapping around to the far side of the screen.
    logic signed [10:0] ox;
    logic signed [10:0] oy;
    logic signed [10:0] dc;
    logic signed [10:0] dr;
    logic               in_col;
    logic               in_row;
    logic               hit_d;

    always_comb begin
        ox     = signed'(11'(sloc_x) << LOC_SHIFT) - HALF;
        oy     = signed'(11'(sloc_y) << LOC_SHIFT) - HALF;
        dc     = signed'({1'b0, pixel_column}) - ox;
        dr     = signed'({1'b0, pixel_row}) - oy;
        // Non-negative and below ICON_SIZE <=> all bits above the index are 0
        in_col = (dc[10:IW] == '0);
        in_row = (dr[10:IW] == '0);
        hit_d  = video_on_in && in_col && in_row;
    end

    logic          s1_hit;
    logic [IW-1:0] s1_r;
    logic [IW-1:0] s1_c;
    logic          s1_von;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            s1_hit <= 1'b0;
            s1_r   <= '0;
            s1_c   <= '0;
            s1_von <= 1'b0;
        end else begin
            s1_hit <= hit_d;
            s1_r   <= dr[IW-1:0];
            s1_c   <= dc[IW-1:0];
            s1_von <= video_on_in;
        end
    end

    // Stage 2: rotate by quarter turns, then look the pixel up in the
    // north or north-east table.
    logic [IW-1:0] sr;
    logic [IW-1:0] sc;
    logic [RW-1:0] row_val;
    logic [RW-1:0] row_shift;
    logic [1:0]    pix;
    logic          blank;

    always_comb begin
        sr = s1_r;
        sc = s1_c;
        case (sorient[2:1])
            2'd0: begin sr = s1_r;        sc = s1_c;        end
            2'd1: begin sr = IMAX - s1_c; sc = s1_r;        end
            2'd2: begin sr = IMAX - s1_r; sc = IMAX - s1_c; end
            2'd3: begin sr = s1_c;        sc = IMAX - s1_r; end
            default: ;
        endcase
        row_val   = sorient[0] ? ICON_45[sr] : ICON_0[sr];
        row_shift = row_val << {sc, 1'b0};
        pix       = row_shift[RW-1 -: 2];
        // Hidden for the second half of every blink period while stalled
        blank     = sstall && blink_cnt[BW-1];
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            icon         <= 2'b00;
            video_on_out <= 1'b0;
        end else begin
            icon         <= (s1_hit && !blank) ? pix : 2'b00;
            video_on_out <= s1_von;
        end
    end

endmodule

// File: tb/tb_icon_sprite.sv
module tb_icon_sprite;

    logic       clock = 1'b0;
    logic       rst;
    logic [9:0] pixel_row;
    logic [9:0] pixel_column;
    logic       video_on_in;
    logic       frame_tick;
    logic [7:0] loc_x;
    logic [7:0] loc_y;
    logic [2:0] orient;
    logic       bot_stalled;
    logic [1:0] icon;
    logic       video_on_out;

    int checks   = 0;
    int failures = 0;

    // Bench-side copy of the shadow state
    int m_sx = 0, m_sy = 0, m_sor = 0, m_sst = 0, m_blink = 0;

    // Scan bookkeeping
    logic [1:0] pipe0, pipe1;
    int prow0, pcol0, prow1, pcol1, valid;
    int mism, nz_in, nz_out, exp_nz, hidden;

    localparam logic [31:0] T0 [16] = '{
        32'h0003C000, 32'h0003C000, 32'h000FF000, 32'h000EB000,
        32'h003AAC00, 32'h003AAC00, 32'h00EAAB00, 32'h00EAAB00,
        32'h03AAAAC0, 32'h03AAAAC0, 32'h0EA55AB0, 32'h0EA55AB0,
        32'h3AA55AAC, 32'h3A9009AC, 32'h35000053, 32'h14000014
    };
    localparam logic [31:0] T45 [16] = '{
        32'h00000003, 32'h0000003F, 32'h000003EC, 32'h00003EA8,
        32'h0003EAA0, 32'h003EAA80, 32'h03EAAA00, 32'h3EAA6800,
        32'h00A56800, 32'h00256000, 32'h00158000, 32'h00154000,
        32'h00050000, 32'h00040000, 32'h00000000, 32'h00000000
    };

    icon_sprite dut (
        .clock        (clock),
        .rst          (rst),
        .pixel_row    (pixel_row),
        .pixel_column (pixel_column),
        .video_on_in  (video_on_in),
        .frame_tick   (frame_tick),
        .loc_x        (loc_x),
        .loc_y        (loc_y),
        .orient       (orient),
        .bot_stalled  (bot_stalled),
        .icon         (icon),
        .video_on_out (video_on_out)
    );

    always #20 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model(input int row, input int col, input bit von);
        int ox, oy, r, c, sr, sc;
        logic [31:0] rv;
        ox = m_sx * 4 - 8;
        oy = m_sy * 4 - 8;
        r  = row - oy;
        c  = col - ox;
        if (!von || r < 0 || r > 15 || c < 0 || c > 15) return 2'b00;
        if (m_sst != 0 && m_blink >= 16) return 2'b00;
        case (m_sor / 2)
            0: begin sr = r;      sc = c;      end
            1: begin sr = 15 - c; sc = r;      end
            2: begin sr = 15 - r; sc = 15 - c; end
            default: begin sr = c; sc = 15 - r; end
        endcase
        rv = (m_sor % 2 != 0) ? T45[sr] : T0[sr];
        return rv[31 - 2 * sc -: 2];
    endfunction

    task automatic tick();
        @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        m_sx    = int'(loc_x);
        m_sy    = int'(loc_y);
        m_sor   = int'(orient);
        m_sst   = int'(bot_stalled);
        m_blink = (m_blink + 1) % 32;
    endtask

    task automatic set_pix(input int row, input int col, input bit von);
        pixel_row    = 10'(row);
        pixel_column = 10'(col);
        video_on_in  = von;
    endtask

    task automatic probe(input string tag, input int row, input int col, input bit von,
                         input int exp);
        @(negedge clock);
        set_pix(row, col, von);
        @(posedge clock);
        @(posedge clock);
        #1;
        chk(tag, int'(icon), exp);
    endtask

    task automatic scan_step(input int row, input int col, input bit von);
        @(negedge clock);
        if (valid >= 2) begin
            if (icon != pipe1) mism++;
            if (pipe1 != 2'b00) exp_nz++;
            if (icon != 2'b00) begin
                if (prow1 < 8 && pcol1 < 8) nz_in++;
                else nz_out++;
            end
        end
        pipe1 = pipe0; prow1 = prow0; pcol1 = pcol0;
        pipe0 = model(row, col, von); prow0 = row; pcol0 = col;
        valid++;
        set_pix(row, col, von);
    endtask

    initial begin
        rst = 1'b0;
        set_pix(0, 0, 1'b0);
        frame_tick  = 1'b0;
        loc_x       = 8'd0;
        loc_y       = 8'd0;
        orient      = 3'd0;
        bot_stalled = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_icon", int'(icon), 0);
        chk("reset_von", int'(video_on_out), 0);
        rst = 1'b1;

        // 1: nose of the north sprite, exact 2-cycle latency
        loc_x = 8'd20; loc_y = 8'd20; orient = 3'd0;
        tick();
        probe("t1_above_nose", 71, 79, 1'b1, 0);
        @(negedge clock);
        set_pix(72, 79, 1'b1);
        @(posedge clock); #1;
        chk("t1_lat1", int'(icon), 0);
        @(posedge clock); #1;
        chk("t1_nose", int'(icon), 3);

        // 2: rotations; each probe lands on the table nose
        orient = 3'd2; tick();
        probe("t2_east_nose", 79, 87, 1'b1, 3);
        orient = 3'd4; tick();
        probe("t2_south_nose", 87, 80, 1'b1, 3);
        orient = 3'd6; tick();
        probe("t2_west_nose", 80, 72, 1'b1, 3);
        orient = 3'd1; tick();
        probe("t2_ne_nose", 72, 87, 1'b1, 3);
        probe("t2_ne_corner", 87, 72, 1'b1, 0);
        orient = 3'd3; tick();
        probe("t2_se_nose", 87, 87, 1'b1, 3);
        probe("t2_se_model", 80, 80, 1'b1, int'(model(80, 80, 1'b1)));

        // 3: sprite at the top-left corner, clipped, no wrap
        loc_x = 8'd0; loc_y = 8'd0; orient = 3'd0; tick();
        mism = 0; nz_in = 0; nz_out = 0; exp_nz = 0; valid = 0;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 640; c++) scan_step(r, c, 1'b1);
        for (int r = 470; r < 480; r++)
            for (int c = 0; c < 640; c++) scan_step(r, c, 1'b1);
        scan_step(0, 0, 1'b0);
        scan_step(0, 0, 1'b0);
        chk("t3_mismatches", mism, 0);
        chk("t3_outside", nz_out, 0);
        chk("t3_inside", nz_in, exp_nz);
        chk("t3_some_visible", int'(nz_in > 0), 1);
        probe("t3_corner", 0, 0, 1'b1, 2);
        probe("t3_far_corner", 479, 639, 1'b1, 0);

        // 4: position changes only take effect at the tick
        loc_x = 8'd20; loc_y = 8'd20; tick();
        loc_x = 8'd40;
        probe("t4_old_before", 72, 79, 1'b1, 3);
        probe("t4_new_before", 72, 159, 1'b1, 0);
        tick();
        probe("t4_old_after", 72, 79, 1'b1, 0);
        probe("t4_new_after", 72, 159, 1'b1, 3);

        // 5: blinking while stalled
        bot_stalled = 1'b1;
        hidden = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            probe("t5_blink", 72, 159, 1'b1, (m_blink >= 16) ? 0 : 3);
            if (icon == 2'b00) hidden++;
        end
        chk("t5_hidden_frames", hidden, 32);
        bot_stalled = 1'b0;
        hidden = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            probe("t5_no_blink", 72, 159, 1'b1, 3);
            if (icon == 2'b00) hidden++;
        end
        chk("t5_never_hidden", hidden, 0);

        // 6: blanking, video_on delay, async reset
        probe("t6_blank_icon", 72, 159, 1'b0, 0);
        chk("t6_blank_von", int'(video_on_out), 0);
        @(negedge clock);
        set_pix(72, 159, 1'b1);
        @(posedge clock); #1;
        chk("t6_von_lat1", int'(video_on_out), 0);
        @(posedge clock); #1;
        chk("t6_von_lat2", int'(video_on_out), 1);
        chk("t6_icon_on", int'(icon), 3);
        #5 rst = 1'b0;
        #1;
        chk("t6_rst_icon", int'(icon), 0);
        chk("t6_rst_von", int'(video_on_out), 0);
        @(negedge clock);
        @(negedge clock);
        rst = 1'b1;
        m_sx = 0; m_sy = 0; m_sor = 0; m_sst = 0; m_blink = 0;
        probe("t6_shadow_cleared", 0, 0, 1'b1, 2);
        probe("t6_old_pos_gone", 72, 159, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
